fpu_mac_seq: RTL and testbench

FPU_MAC_SEQ -- requirements
Module: fpu_mac_seq

---
 rtl/fpu_mac_seq.sv | 140 ++++++++++++++
 tb/tb_fpu_mac_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mac_seq.sv
// fpu_mac_seq: command FIFO sequencing operand pairs into an Avalon-MM MAC slave and reading back the result.
// Build option FPU_MAC_SEQ_TIMEOUT_EN compiles in the wait-state watchdog and the ERR recovery path.
module fpu_mac_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_op_a,
    input  logic [63:0] cmd_op_b,
    input  logic        cmd_last,
    output logic        res_valid,
    output logic [63:0] res_data,
    input  logic        res_ready,
    output logic [2:0]  m_address,
    output logic [63:0] m_writedata,
    output logic        m_write,
    output logic        m_read,
    input  logic [63:0] m_readdata,
    input  logic        m_waitrequest,
    input  logic        err_clr,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] pair_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, WR_A, WR_B, WAIT_BUSY, WAIT_DONE, RD, OUT, ERR} state_t;

    state_t        state_q, state_d;
    logic [128:0]  fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [128:0]  head;
    logic          last_q, m_write_q, m_read_q;
    logic [2:0]    m_address_q;
    logic [63:0]   m_writedata_q, res_data_q;
    logic [15:0]   pair_count_q;
    logic          push, pop, flush, clr;

    assign head      = fifo_q[rd_ptr_q];
    assign cmd_ready = count_q != (AW+1)'(FIFO_DEPTH) && state_q != ERR;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state_q == WR_B && !m_waitrequest;
    assign flush     = state_q == ERR;

    assign busy        = state_q != IDLE;
    assign res_valid   = state_q == OUT;
    assign res_data    = res_data_q;
    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;
    assign m_write     = m_write_q;
    assign m_read      = m_read_q;
    assign pair_count  = pair_count_q;

`ifdef FPU_MAC_SEQ_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        wd_expired;

    assign wd_expired  = state_q inside {WAIT_BUSY, WAIT_DONE, RD} && wd_q == 16'(TIMEOUT - 1);
    assign timeout_err = state_q == ERR;
    assign clr         = (state_q == OUT && res_ready) || (state_q == ERR && err_clr);

    // watchdog restarts whenever the FSM changes state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wd_q <= '0;
        else        wd_q <= state_d != state_q ? '0 : wd_q + 16'd1;
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^{err_clr, 32'(TIMEOUT)};
    assign timeout_err = 1'b0;
    assign clr         = state_q == OUT && res_ready;
`endif

    // next-state: the MAC handshake sequence; a stall past the watchdog limit diverts to ERR
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = count_q != '0 ? WR_A : IDLE;
            WR_A:      state_d = m_waitrequest ? WR_A : WR_B;
            WR_B:      state_d = m_waitrequest ? WR_B : WAIT_BUSY;
            WAIT_BUSY: state_d = m_waitrequest ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_d = m_waitrequest ? WAIT_DONE : (last_q ? RD : IDLE);
            RD:        state_d = m_waitrequest ? RD : OUT;
            OUT:       state_d = res_ready ? IDLE : OUT;
`ifdef FPU_MAC_SEQ_TIMEOUT_EN
            ERR:       state_d = err_clr ? IDLE : ERR;
`endif
            default:   state_d = IDLE;
        endcase
`ifdef FPU_MAC_SEQ_TIMEOUT_EN
        if (wd_expired && state_d == state_q) state_d = ERR;
`endif
    end

    // command storage; no reset needed since occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {cmd_last, cmd_op_b, cmd_op_a};
    end

    // FIFO pointers; ERR discards everything queued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= flush ? wr_ptr_q : rd_ptr_q + AW'(pop);
            count_q  <= flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // state and registered master outputs decoded from the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            m_write_q     <= 1'b0;
            m_read_q      <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            last_q        <= 1'b0;
            res_data_q    <= '0;
            pair_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            m_write_q     <= state_d == WR_A || state_d == WR_B;
            m_read_q      <= state_d == RD;
            m_address_q   <= state_d == WR_B ? 3'd1 : state_d == RD ? 3'd2 : 3'd0;
            m_writedata_q <= state_d == WR_A ? head[63:0] : state_d == WR_B ? head[127:64] : m_writedata_q;
            last_q        <= pop ? head[128] : last_q;
            res_data_q    <= state_q == RD && !m_waitrequest ? m_readdata : res_data_q;
            pair_count_q  <= pop ? pair_count_q + 16'd1 : clr ? '0 : pair_count_q;
        end
    end
endmodule

// File: tb/tb_fpu_mac_seq.sv
// tb_fpu_mac_seq: directed bench for fpu_mac_seq with a hand-driven MAC slave.
module tb_fpu_mac_seq;
    logic        clk = 1'b0, reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_last = 1'b0, res_ready = 1'b0, err_clr = 1'b0;
    logic        m_waitrequest = 1'b0;
    logic [63:0] cmd_op_a = '0, cmd_op_b = '0, m_readdata = '0;
    logic        cmd_ready, res_valid, m_write, m_read, busy, timeout_err;
    logic [63:0] res_data, m_writedata;
    logic [2:0]  m_address;
    logic [15:0] pair_count;
    int          errs = 0, checks = 0;

    fpu_mac_seq #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_last(cmd_last),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write), .m_read(m_read),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .err_clr(err_clr),
        .busy(busy), .timeout_err(timeout_err), .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if ({cmd_ready, res_valid, m_write, m_read, busy, timeout_err} !== 6'b100000) begin errs++; $display("FAIL reset_flags got %b exp 100000", {cmd_ready, res_valid, m_write, m_read, busy, timeout_err}); end
        checks++; if ({pair_count, m_address, res_data, m_writedata} !== '0) begin errs++; $display("FAIL reset_values got pc=%h addr=%h rd=%h wd=%h exp all 0", pair_count, m_address, res_data, m_writedata); end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_single;
        logic [63:0] a = 64'h418e333340866666, b = 64'h421ce3a341280000, r = 64'h00000000443951b0;
        cmd_valid = 1'b1; cmd_op_a = a; cmd_op_b = b; cmd_last = 1'b1;
        tick;
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle_after_push got busy=%b exp 0", busy); end
        tick;
        checks++; if ({m_write, m_read, m_address, m_writedata} !== {1'b1, 1'b0, 3'd0, a}) begin errs++; $display("FAIL single_wr_a got w=%b r=%b addr=%0d data=%h exp w=1 r=0 addr=0 data=%h", m_write, m_read, m_address, m_writedata, a); end
        tick;
        checks++; if ({m_write, m_address, m_writedata} !== {1'b1, 3'd1, b}) begin errs++; $display("FAIL single_wr_b got w=%b addr=%0d data=%h exp w=1 addr=1 data=%h", m_write, m_address, m_writedata, b); end
        tick;
        checks++; if ({m_write, pair_count} !== {1'b0, 16'd1}) begin errs++; $display("FAIL single_pair_count got w=%b pc=%0d exp w=0 pc=1", m_write, pair_count); end
        m_waitrequest = 1'b1;
        repeat (3) tick;
        m_waitrequest = 1'b0;
        tick;
        checks++; if ({m_read, m_write, m_address} !== {1'b1, 1'b0, 3'd2}) begin errs++; $display("FAIL single_rd got r=%b w=%b addr=%0d exp r=1 w=0 addr=2", m_read, m_write, m_address); end
        m_readdata = r;
        tick;
        checks++; if ({res_valid, res_data, m_read, pair_count} !== {1'b1, r, 1'b0, 16'd1}) begin errs++; $display("FAIL single_out got v=%b data=%h r=%b pc=%0d exp v=1 data=%h r=0 pc=1", res_valid, res_data, m_read, pair_count, r); end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        checks++; if ({res_valid, busy, pair_count} !== {1'b0, 1'b0, 16'd0}) begin errs++; $display("FAIL single_consume got v=%b busy=%b pc=%0d exp v=0 busy=0 pc=0", res_valid, busy, pair_count); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] a [4], b [4];
        logic [63:0] r = 64'h0123456789abcdef;
        for (int i = 0; i < 4; i++) begin
            a[i] = 64'h1111_0000_0000_0000 + 64'(i);
            b[i] = 64'h2222_0000_0000_0000 + 64'(i);
        end
        m_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_op_a = a[i]; cmd_op_b = b[i]; cmd_last = i == 3;
            tick;
        end
        cmd_valid = 1'b0; cmd_last = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL b2b_full got cmd_ready=%b exp 0", cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({m_write, m_address, m_writedata} !== {1'b1, 3'd0, a[i]}) begin errs++; $display("FAIL b2b_wr_a%0d got w=%b addr=%0d data=%h exp w=1 addr=0 data=%h", i, m_write, m_address, m_writedata, a[i]); end
            m_waitrequest = 1'b0;
            tick;
            checks++; if ({m_address, m_writedata} !== {3'd1, b[i]}) begin errs++; $display("FAIL b2b_wr_b%0d got addr=%0d data=%h exp addr=1 data=%h", i, m_address, m_writedata, b[i]); end
            tick;
            checks++; if (pair_count !== 16'(i + 1)) begin errs++; $display("FAIL b2b_pair_count%0d got %0d exp %0d", i, pair_count, i + 1); end
            if (i == 0) begin
                checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_after_pop got %b exp 1", cmd_ready); end
            end
            m_waitrequest = 1'b1;
            tick;
            m_waitrequest = 1'b0;
            tick;
            if (i < 3) begin
                checks++; if (m_read !== 1'b0) begin errs++; $display("FAIL b2b_no_read%0d got m_read=%b exp 0", i, m_read); end
                tick;
            end
        end
        checks++; if ({m_read, m_address, pair_count} !== {1'b1, 3'd2, 16'd4}) begin errs++; $display("FAIL b2b_rd got r=%b addr=%0d pc=%0d exp r=1 addr=2 pc=4", m_read, m_address, pair_count); end
        m_readdata = r;
        tick;
        checks++; if ({res_valid, res_data} !== {1'b1, r}) begin errs++; $display("FAIL b2b_result got v=%b data=%h exp v=1 data=%h", res_valid, res_data, r); end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        checks++; if ({busy, pair_count} !== {1'b0, 16'd0}) begin errs++; $display("FAIL b2b_done got busy=%b pc=%0d exp busy=0 pc=0", busy, pair_count); end
    endtask

    task automatic test_stall;
        logic [63:0] a = 64'h3ff0000000000000, b = 64'h4000000000000000;
        m_waitrequest = 1'b1;
        cmd_valid = 1'b1; cmd_op_a = a; cmd_op_b = b; cmd_last = 1'b0;
        tick;
        cmd_valid = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            checks++; if ({m_write, m_address, m_writedata} !== {1'b1, 3'd0, a}) begin errs++; $display("FAIL stall_hold%0d got w=%b addr=%0d data=%h exp w=1 addr=0 data=%h", k, m_write, m_address, m_writedata, a); end
            tick;
        end
        m_waitrequest = 1'b0;
        tick;
        checks++; if ({m_address, m_writedata} !== {3'd1, b}) begin errs++; $display("FAIL stall_wr_b got addr=%0d data=%h exp addr=1 data=%h", m_address, m_writedata, b); end
        tick;
        m_waitrequest = 1'b1;
        tick;
        m_waitrequest = 1'b0;
        tick;
        checks++; if ({busy, m_read, pair_count} !== {1'b0, 1'b0, 16'd1}) begin errs++; $display("FAIL stall_single_count got busy=%b r=%b pc=%0d exp busy=0 r=0 pc=1", busy, m_read, pair_count); end
    endtask

    task automatic test_out_hold;
        logic [63:0] r = 64'hcafe_f00d_1234_5678;
        cmd_valid = 1'b1; cmd_op_a = 64'h5; cmd_op_b = 64'h6; cmd_last = 1'b1;
        tick;
        cmd_valid = 1'b0; cmd_last = 1'b0;
        repeat (3) tick;
        m_waitrequest = 1'b1;
        tick;
        m_waitrequest = 1'b0;
        tick;
        m_readdata = r;
        tick;
        m_readdata = 64'hdead_beef_dead_beef;
        checks++; if (pair_count !== 16'd2) begin errs++; $display("FAIL hold_pair_count got %0d exp 2", pair_count); end
        for (int k = 0; k < 10; k++) begin
            checks++; if ({res_valid, res_data} !== {1'b1, r}) begin errs++; $display("FAIL hold_stable%0d got v=%b data=%h exp v=1 data=%h", k, res_valid, res_data, r); end
            if (k < 2) begin
                cmd_valid = 1'b1; cmd_op_a = 64'hA0 + 64'(k); cmd_op_b = 64'hB0 + 64'(k);
                checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL hold_accept%0d got cmd_ready=%b exp 1", k, cmd_ready); end
            end else cmd_valid = 1'b0;
            tick;
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        checks++; if ({res_valid, pair_count} !== {1'b0, 16'd0}) begin errs++; $display("FAIL hold_release got v=%b pc=%0d exp v=0 pc=0", res_valid, pair_count); end
    endtask

    task automatic test_reset_mid;
        tick;
        checks++; if ({m_write, m_address, m_writedata} !== {1'b1, 3'd0, 64'hA0}) begin errs++; $display("FAIL mid_queued_wr_a got w=%b addr=%0d data=%h exp w=1 addr=0 data=a0", m_write, m_address, m_writedata); end
        tick;
        checks++; if ({m_write, m_address} !== {1'b1, 3'd1}) begin errs++; $display("FAIL mid_wr_b got w=%b addr=%0d exp w=1 addr=1", m_write, m_address); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({m_write, cmd_ready, res_valid, busy, m_address} !== {1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin errs++; $display("FAIL mid_async_reset got w=%b ready=%b v=%b busy=%b addr=%0d exp w=0 ready=1 v=0 busy=0 addr=0", m_write, cmd_ready, res_valid, busy, m_address); end
        @(posedge clk);
        #1 reset = 1'b1;
        tick;
        tick;
        checks++; if ({busy, cmd_ready, m_write} !== {1'b0, 1'b1, 1'b0}) begin errs++; $display("FAIL mid_fifo_empty got busy=%b ready=%b w=%b exp busy=0 ready=1 w=0", busy, cmd_ready, m_write); end
    endtask

    task automatic test_timeout;
        m_waitrequest = 1'b0;
        cmd_valid = 1'b1; cmd_op_a = 64'h7; cmd_op_b = 64'h8; cmd_last = 1'b0;
        tick;
        cmd_valid = 1'b0;
        repeat (3) tick;
        checks++; if ({pair_count, busy} !== {16'd1, 1'b1}) begin errs++; $display("FAIL to_wait_busy got pc=%0d busy=%b exp pc=1 busy=1", pair_count, busy); end
        cmd_valid = 1'b1; cmd_op_a = 64'h9;
        tick;
        cmd_valid = 1'b0;
`ifdef FPU_MAC_SEQ_TIMEOUT_EN
        repeat (14) tick;
        checks++; if ({timeout_err, busy} !== 2'b01) begin errs++; $display("FAIL to_before_limit got err=%b busy=%b exp err=0 busy=1", timeout_err, busy); end
        tick;
        checks++; if ({timeout_err, cmd_ready, m_write, m_read} !== 4'b1000) begin errs++; $display("FAIL to_expired got err=%b ready=%b w=%b r=%b exp err=1 ready=0 w=0 r=0", timeout_err, cmd_ready, m_write, m_read); end
        tick;
        tick;
        checks++; if ({timeout_err, busy} !== 2'b11) begin errs++; $display("FAIL to_sticky got err=%b busy=%b exp 11", timeout_err, busy); end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if ({timeout_err, busy, pair_count} !== {1'b0, 1'b0, 16'd0}) begin errs++; $display("FAIL to_clear got err=%b busy=%b pc=%0d exp err=0 busy=0 pc=0", timeout_err, busy, pair_count); end
        tick;
        tick;
        checks++; if ({busy, cmd_ready} !== 2'b01) begin errs++; $display("FAIL to_flushed got busy=%b ready=%b exp busy=0 ready=1", busy, cmd_ready); end
`else
        repeat (40) tick;
        checks++; if ({timeout_err, busy} !== 2'b01) begin errs++; $display("FAIL nowd_waiting got err=%b busy=%b exp err=0 busy=1", timeout_err, busy); end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++; if ({timeout_err, busy, pair_count} !== {1'b0, 1'b1, 16'd1}) begin errs++; $display("FAIL nowd_err_clr_ignored got err=%b busy=%b pc=%0d exp err=0 busy=1 pc=1", timeout_err, busy, pair_count); end
        m_waitrequest = 1'b1;
        tick;
        m_waitrequest = 1'b0;
        tick;
        checks++; if ({busy, m_read} !== 2'b00) begin errs++; $display("FAIL nowd_resume got busy=%b r=%b exp 00", busy, m_read); end
`endif
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_stall;
        test_out_hold;
        test_reset_mid;
        test_timeout;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
